// File: rtl/run_host.sv
// Host-side launcher for the TopLevel core: clears data memory, preloads the
// program's input bytes while the core is parked (Start=1), launches it with a
// falling edge on Start, waits for Ack, then streams the result bytes out of
// data memory on a valid/ready interface.
module run_host #(
  parameter int AW        = 8,
  parameter int LOAD_BASE = 128,
  parameter int LOAD_LEN  = 8,
  parameter int RES_BASE  = 5,
  parameter int RES_LEN   = 4,
  parameter int TIMEOUT   = 65535
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Go,
  input  logic [7:0]    InData,
  input  logic          InValid,
  output logic          InReady,
  output logic          Start,
  input  logic          Ack,
  output logic [AW-1:0] DmAddr,
  output logic          DmWrEn,
  output logic [7:0]    DmWrData,
  input  logic [7:0]    DmRdData,
  output logic [7:0]    OutData,
  output logic          OutValid,
  input  logic          OutReady,
  output logic          Busy,
  output logic          Done,
  output logic          Err
);

  localparam int LW = $clog2(LOAD_LEN + 1);
  localparam int RW = $clog2(RES_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [AW-1:0] LOAD_BASE_A = AW'(LOAD_BASE);
  localparam logic [AW-1:0] RES_BASE_A  = AW'(RES_BASE);
  localparam logic [LW-1:0] LOAD_LAST   = LW'(LOAD_LEN - 1);
  localparam logic [RW-1:0] RES_LAST    = RW'(RES_LEN - 1);
  localparam logic [TW-1:0] WAIT_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, LOAD, LAUNCH, WAIT, READ, DONE, ERR
  } state_t;

  state_t        state;
  logic [AW-1:0] addr_q;    // clear sweep address, then result read address
  logic [LW-1:0] load_cnt;  // input bytes accepted so far
  logic [RW-1:0] res_cnt;   // result bytes handed off so far
  logic [TW-1:0] wait_cnt;  // WAIT cycles spent without Ack

  logic load_fire;

  assign load_fire = (state == LOAD) && InValid && InReady;

  // Write port: clear sweep from the address register, load writes follow the
  // input handshake combinationally so a byte lands in the cycle it is accepted.
  // NOTE: plain continuous assigns give every output a value in every state, so no latch can appear.
  assign DmWrEn   = (state == CLEAR) || load_fire;
  assign DmAddr   = (state == LOAD) ? LOAD_BASE_A + AW'(load_cnt) : addr_q;
  assign DmWrData = load_fire ? InData : 8'h00;

  // Sequence controller with registered handshake and status outputs.
  always_ff @(posedge Clk) begin
    // NOTE: reset is synchronous, so it is tested inside the edge-triggered body, not in the sensitivity list.
    if (!Reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      load_cnt <= '0;
      res_cnt  <= '0;
      wait_cnt <= '0;
      Start    <= 1'b1;
      InReady  <= 1'b0;
      OutValid <= 1'b0;
      OutData  <= 8'h00;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Err      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register here see pre-edge values, independent of statement order.
      case (state)
        IDLE, DONE, ERR: begin
          if (Go) begin
            state  <= CLEAR;
            addr_q <= '0;
            Busy   <= 1'b1;
            Done   <= 1'b0;
            Err    <= 1'b0;
          end
        end

        CLEAR: begin
          addr_q <= addr_q + 1'b1;
          if (addr_q == '1) begin
            state    <= LOAD;
            InReady  <= 1'b1;
            load_cnt <= '0;
          end
        end

        LOAD: begin
          if (load_fire) begin
            load_cnt <= load_cnt + 1'b1;
            if (load_cnt == LOAD_LAST) begin
              state   <= LAUNCH;
              InReady <= 1'b0;
              Start   <= 1'b0;
            end
          end
        end

        LAUNCH: begin
          state    <= WAIT;
          wait_cnt <= '0;
        end

        WAIT: begin
          if (Ack) begin
            state    <= READ;
            addr_q   <= RES_BASE_A;
            res_cnt  <= '0;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= ERR;
            Start    <= 1'b1;
            Busy     <= 1'b0;
            Err      <= 1'b1;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        READ: begin
          // OutValid low marks the address cycle; high marks the hold-until-ready cycle.
          if (!OutValid) begin
            OutData  <= DmRdData;
            OutValid <= 1'b1;
          end else if (OutReady) begin
            OutValid <= 1'b0;
            if (res_cnt == RES_LAST) begin
              state   <= DONE;
              Start   <= 1'b1;
              Busy    <= 1'b0;
              Done    <= 1'b1;
              addr_q  <= '0;
              res_cnt <= '0;
            end else begin
              res_cnt <= res_cnt + 1'b1;
              addr_q  <= addr_q + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_host.sv
// Bench for run_host: a data-memory model and a behavioural core drive the
// host through complete runs (table rows plus randomized runs), reset aborts,
// and an Ack timeout on a second instance built with a short TIMEOUT.
module tb_run_host;

  localparam int AW        = 8;
  localparam int DEPTH     = 256;
  localparam int LOAD_BASE = 128;
  localparam int LOAD_LEN  = 8;
  localparam int RES_BASE  = 5;
  localparam int RES_LEN   = 4;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          Go = 1'b0;
  logic [7:0]    InData = 8'h00;
  logic          InValid = 1'b0;
  logic          Ack = 1'b0;
  logic          OutReady = 1'b0;
  logic          InReady, Start, DmWrEn, OutValid, Busy, Done, Err;
  logic [AW-1:0] DmAddr;
  logic [7:0]    DmWrData, DmRdData, OutData;

  // Second instance used only for the Ack-timeout scenario.
  logic          go2 = 1'b0;
  logic          ack2 = 1'b0;
  logic          in_ready2, start2, dm_wr_en2, out_valid2, busy2, done2, err2;
  logic [AW-1:0] dm_addr2;
  logic [7:0]    dm_wr_data2, out_data2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int port_viol = 0;

  logic          scramble = 1'b0;
  logic          core_wr = 1'b0;
  logic [31:0]   core_res = 32'h0;
  logic [7:0]    dm [DEPTH];

  run_host #(
    .AW(AW), .LOAD_BASE(LOAD_BASE), .LOAD_LEN(LOAD_LEN),
    .RES_BASE(RES_BASE), .RES_LEN(RES_LEN), .TIMEOUT(65535)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Go(Go), .InData(InData), .InValid(InValid),
    .InReady(InReady), .Start(Start), .Ack(Ack), .DmAddr(DmAddr),
    .DmWrEn(DmWrEn), .DmWrData(DmWrData), .DmRdData(DmRdData),
    .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady),
    .Busy(Busy), .Done(Done), .Err(Err)
  );

  run_host #(
    .AW(AW), .LOAD_BASE(LOAD_BASE), .LOAD_LEN(LOAD_LEN),
    .RES_BASE(RES_BASE), .RES_LEN(RES_LEN), .TIMEOUT(16)
  ) dut_to (
    .Clk(Clk), .Reset(Reset), .Go(go2), .InData(8'h5a), .InValid(1'b1),
    .InReady(in_ready2), .Start(start2), .Ack(ack2), .DmAddr(dm_addr2),
    .DmWrEn(dm_wr_en2), .DmWrData(dm_wr_data2), .DmRdData(8'h00),
    .OutData(out_data2), .OutValid(out_valid2), .OutReady(1'b1),
    .Busy(busy2), .Done(done2), .Err(err2)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Data memory: host write port, core result writes, and a junk fill so the
  // clear sweep has something to erase.
  always @(posedge Clk) begin
    if (scramble) begin
      for (int a = 0; a < DEPTH; a++) dm[a] <= 8'((a * 37 + 11) ^ cyc);
    end else begin
      if (DmWrEn) dm[DmAddr] <= DmWrData;
      if (core_wr) begin
        for (int k = 0; k < RES_LEN; k++) dm[RES_BASE + k] <= core_res[31 - 8 * k -: 8];
      end
    end
  end
  assign DmRdData = dm[DmAddr];

  // The write port must only be used while the core is parked and a sequence is running.
  always @(negedge Clk) begin
    if (DmWrEn && (!Start || !Busy)) port_viol <= port_viol + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [63:0] load_bytes;   // first byte in the top octet
    logic [31:0] res_bytes;    // bytes the core model leaves at RES_BASE..
    int          ack_delay;    // Ack asserted this many cycles after the launch cycle
    int          in_gap;       // idle InValid cycles before each byte after the first
    int          stall;        // OutReady-low cycles on the second result byte
    int          abort_at;     // 0 none, 1 reset mid-load, 2 reset mid-read
    bit          rnd;          // random gaps/ready, expectations from the model
    logic [31:0] exp_stream;
    int          exp_cycles;   // Go cycle to first Done cycle, -1 = not checked
  } run_vec_t;

  // Called at posedge+1; Reset is sampled on the next edge.
  task automatic reset_abort(input string tag);
    Reset = 1'b0;
    @(posedge Clk); #1;
    @(negedge Clk);
    check({tag, "_strobes"}, 64'({Start, DmWrEn, InReady, OutValid, Busy, Done, Err}), 64'(7'b1000000));
    check({tag, "_regs"}, 64'({DmAddr, DmWrData, OutData}), 64'(0));
    @(posedge Clk); #1;
    Reset = 1'b1;
    InValid = 1'b0;
    OutReady = 1'b0;
    Ack = 1'b0;
  endtask

  // Entered and left at posedge+1.
  task automatic do_run(input run_vec_t v, input string tag);
    logic [7:0]  lb [LOAD_LEN];
    logic [7:0]  ref_dm [DEPTH];
    logic [31:0] exp_s;
    logic        start_prev;
    int          go_cyc, last_cyc, launch_cyc, rx, stall_left, nbad, gap;
    bit          ok, fin;

    for (int i = 0; i < LOAD_LEN; i++) lb[i] = v.load_bytes[63 - 8 * i -: 8];
    for (int a = 0; a < DEPTH; a++) ref_dm[a] = 8'h00;
    for (int i = 0; i < LOAD_LEN; i++) ref_dm[LOAD_BASE + i] = lb[i];

    scramble = 1'b1;
    @(posedge Clk); #1;
    scramble = 1'b0;
    Go = 1'b1;
    go_cyc = cyc;
    @(posedge Clk); #1;
    Go = 1'b0;

    start_prev = 1'b0;
    last_cyc = 0;
    for (int i = 0; i < LOAD_LEN; i++) begin
      gap = v.rnd ? int'($urandom_range(3)) : v.in_gap;
      if (i > 0) begin
        repeat (gap) begin
          InValid = 1'b0;
          @(posedge Clk); #1;
        end
      end
      InValid = 1'b1;
      InData = lb[i];
      ok = 1'b0;
      for (int b = 0; b < 400; b++) begin
        @(negedge Clk);
        if (InReady) begin
          ok = 1'b1;
          last_cyc = cyc;
          start_prev = Start;
          if (i == LOAD_LEN - 1)
            check({tag, "_last_write"}, 64'({DmWrEn, DmAddr, DmWrData}),
                  64'({1'b1, 8'(LOAD_BASE + LOAD_LEN - 1), lb[i]}));
        end
        @(posedge Clk); #1;
        if (ok) break;
      end
      if (!ok) begin
        check({tag, "_load_accept"}, 64'(ok), 64'(1));
        InValid = 1'b0;
        return;
      end
      if (v.abort_at == 1 && i == 2) begin
        InData = lb[3];
        reset_abort({tag, "_abort_load"});
        return;
      end
    end

    // Launch cycle: the core model deposits its results in memory.
    InValid = 1'b0;
    launch_cyc = last_cyc + 1;
    core_res = v.res_bytes;
    core_wr = 1'b1;
    @(negedge Clk);
    check({tag, "_start_fall"}, 64'({start_prev, Start}), 64'(2'b10));
    nbad = 0;
    for (int a = 0; a < DEPTH; a++) if (dm[a] !== ref_dm[a]) nbad++;
    check({tag, "_dm_image_bad"}, 64'(nbad), 64'(0));
    @(posedge Clk); #1;
    core_wr = 1'b0;

    for (int k = 0; k < RES_LEN; k++) ref_dm[RES_BASE + k] = v.res_bytes[31 - 8 * k -: 8];
    if (v.rnd) begin
      for (int k = 0; k < RES_LEN; k++) exp_s[31 - 8 * k -: 8] = ref_dm[RES_BASE + k];
    end else begin
      exp_s = v.exp_stream;
    end

    while (cyc < launch_cyc + v.ack_delay) begin
      @(posedge Clk); #1;
    end
    Ack = 1'b1;
    @(posedge Clk); #1;
    Ack = 1'b0;

    rx = 0;
    stall_left = v.stall;
    fin = 1'b0;
    for (int b = 0; b < 300; b++) begin
      if (v.abort_at == 2) OutReady = 1'b0;
      else if (v.rnd) OutReady = ($urandom_range(3) != 0);
      else if (OutValid && rx == 1 && stall_left > 0) begin
        OutReady = 1'b0;
        stall_left--;
      end else OutReady = 1'b1;
      @(negedge Clk);
      if (Done) begin
        fin = 1'b1;
        break;
      end
      if (OutValid) begin
        if (v.abort_at == 2) begin
          @(posedge Clk); #1;
          reset_abort({tag, "_abort_read"});
          return;
        end
        if (rx < RES_LEN) begin
          if (OutReady) check($sformatf("%s_byte%0d", tag, rx), 64'(OutData), 64'(exp_s[31 - 8 * rx -: 8]));
          else check($sformatf("%s_stall_hold%0d", tag, rx), 64'(OutData), 64'(exp_s[31 - 8 * rx -: 8]));
        end
        if (OutReady) rx++;
      end
      @(posedge Clk); #1;
    end
    check({tag, "_done_seen"}, 64'(fin), 64'(1));
    check({tag, "_byte_count"}, 64'(rx), 64'(RES_LEN));
    check({tag, "_end_flags"}, 64'({Done, Start, Busy, Err, OutValid}), 64'(5'b11000));
    if (v.exp_cycles > 0) check({tag, "_go_to_done"}, 64'(cyc - go_cyc), 64'(v.exp_cycles));
    @(posedge Clk); #1;
    OutReady = 1'b0;
  endtask

  // Timeout instance: Ack held high during CLEAR (must be ignored), then never returned.
  task automatic timeout_test();
    int  l_cyc, e_cyc;
    bit  ok;
    ack2 = 1'b1;
    go2 = 1'b1;
    @(posedge Clk); #1;
    go2 = 1'b0;
    ok = 1'b0;
    l_cyc = 0;
    for (int b = 0; b < 600; b++) begin
      @(negedge Clk);
      if (b == 50) ack2 = 1'b0;
      if (!start2) begin
        ok = 1'b1;
        l_cyc = cyc;
        break;
      end
    end
    check("to_launch_seen", 64'(ok), 64'(1));
    ok = 1'b0;
    e_cyc = 0;
    for (int b = 0; b < 100; b++) begin
      @(negedge Clk);
      if (err2) begin
        ok = 1'b1;
        e_cyc = cyc;
        break;
      end
    end
    check("to_err_seen", 64'(ok), 64'(1));
    check("to_err_latency", 64'(e_cyc - l_cyc), 64'(17));
    check("to_err_flags", 64'({err2, start2, busy2, done2}), 64'(4'b1100));
    @(posedge Clk); #1;
    go2 = 1'b1;
    @(posedge Clk); #1;
    go2 = 1'b0;
    @(negedge Clk);
    check("to_restart", 64'({err2, busy2, dm_wr_en2, start2, dm_addr2}), 64'({4'b0111, 8'h00}));
    @(posedge Clk); #1;
  endtask

  initial begin
    run_vec_t tbl [7];
    run_vec_t rv;

    tbl[0] = '{64'h0d10_1314_2a37_4e72, 32'hA1B2C3D4, 20, 0, 0, 0, 1'b0, 32'hA1B2C3D4, 294};
    tbl[1] = '{64'h1122_3344_5566_7788, 32'h5AA53CC3,  1, 2, 3, 0, 1'b0, 32'h5AA53CC3, 292};
    tbl[2] = '{64'hFF00_FF00_807F_01FE, 32'h00FF8001,  1, 0, 0, 0, 1'b0, 32'h00FF8001, 275};
    tbl[3] = '{64'h0102_0304_0506_0708, 32'h11111111,  4, 0, 0, 1, 1'b0, 32'h0, -1};
    tbl[4] = '{64'h0123_4567_89AB_CDEF, 32'hDEADBEEF,  5, 1, 0, 0, 1'b0, 32'hDEADBEEF, 286};
    tbl[5] = '{64'hA0A1_A2A3_A4A5_A6A7, 32'h22334455,  3, 0, 0, 2, 1'b0, 32'h0, -1};
    tbl[6] = '{64'hFEDC_BA98_7654_3210, 32'h13579BDF,  2, 0, 0, 0, 1'b0, 32'h13579BDF, 276};

    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_strobes", 64'({Start, DmWrEn, InReady, OutValid, Busy, Done, Err}), 64'(7'b1000000));
    check("rst_regs", 64'({DmAddr, DmWrData, OutData}), 64'(0));
    check("rst2_strobes", 64'({start2, dm_wr_en2, in_ready2, out_valid2, busy2, done2, err2}), 64'(7'b1000000));
    check("rst2_regs", 64'({dm_addr2, dm_wr_data2, out_data2}), 64'(0));
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;

    timeout_test();

    for (int r = 0; r < 7; r++) do_run(tbl[r], $sformatf("row%0d", r));

    for (int r = 0; r < 4; r++) begin
      rv.load_bytes = {$urandom, $urandom};
      rv.res_bytes  = $urandom;
      rv.ack_delay  = int'($urandom_range(40, 1));
      rv.in_gap     = 0;
      rv.stall      = 0;
      rv.abort_at   = 0;
      rv.rnd        = 1'b1;
      rv.exp_stream = 32'h0;
      rv.exp_cycles = -1;
      do_run(rv, $sformatf("rnd%0d", r));
    end

    check("dm_port_outside_parked_busy", 64'(port_viol), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
